stopwatch_btn_ctrl: RTL and testbench
=====================================

# stopwatch_btn_ctrl

Button conditioning and run/clear control for the Basys3 digital stopwatch. Takes the two raw, bouncing, asynchronous push-buttons (start/stop, clear), synchronizes and debounces them, and produces a clean `run` enable level and a single-cycle `clr_pulse`. It sits directly upstream of the tick counter, which consumes `run` as its count enable and `clr_pulse` as its clear.

## Interface
- `CLK_HZ`, 100_000_000: clk frequency in Hz.
- `DEBOUNCE_MS`, 10: required stable time in ms; DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS, must be ≥ 1.
- `LONGPRESS_MS`, 1000: long-press hold time in ms; LP_CYCLES = CLK_HZ/1000*LONGPRESS_MS. Used only with BTN_LONGPRESS_EN.

- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `btn_ss_raw`  input  1  raw start/stop button, asynchronous, active-high.
- `btn_clr_raw`  input  1  raw clear button, asynchronous, active-high.
- `run`  output  1  registered count enable level for the counter.
- `clr_pulse`  output  1  registered one-cycle clear request.
- `ss_db`  output  1  debounced start/stop level (status/LED).
- `clr_db`  output  1  debounced clear level (status/LED).

## Operation
- Each button passes through a 2-flop synchronizer and then a debounce FSM.
- Debounce FSM states:
  - RELEASED: sync=1 → PRESS_WAIT, cnt=0.
  - PRESS_WAIT: sync=0 → RELEASED. cnt==DB_CYCLES-1 → PRESSED. Otherwise cnt++.
  - PRESSED: sync=0 → RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT: sync=1 → PRESSED. cnt==DB_CYCLES-1 → RELEASED. Otherwise cnt++.
  - Debounced level = 1 in PRESSED and RELEASE_WAIT.
- Rise detect: a debounced 0→1 transition produces a one-cycle internal press strobe. A release generates no event.
- `run` toggles on each start/stop press strobe.
- A clear press strobe forces `run`=0 and asserts `clr_pulse` for exactly one cycle.
- Simultaneous start/stop and clear strobes in the same cycle: clear wins; `run`=0, `clr_pulse`=1, and the start/stop strobe is discarded.
- Clear while stopped still pulses `clr_pulse`.
- Holding a button never repeats its event (only one strobe per press).
- Counter width = $clog2(max(DB_CYCLES, LP_CYCLES)+1). Counters saturate and never wrap.

## Timing
- Reset values: `run`=0, `clr_pulse`=0, `ss_db`=0, `clr_db`=0. Synchronizers, FSMs and counters clear; FSMs go to RELEASED.
- Press latency: raw rises at edge N and stays stable → debounced level rises at edge N+2+DB_CYCLES → `run`/`clr_pulse` update at edge N+3+DB_CYCLES.
- Bounce: any raw pulse shorter than DB_CYCLES cycles (post-sync) produces no output change.
- Reset asserted mid-press: all state clears immediately. A button still held after reset release must be re-debounced and does produce a press event.

## Configuration
- `BTN_LONGPRESS_EN` defined: in the start/stop PRESSED state, a hold counter runs. When the debounced level has stayed high for LP_CYCLES cycles, the block asserts `clr_pulse` for one cycle and forces `run`=0. This fires only once per hold. The toggle from the initial press still occurred.
- `BTN_LONGPRESS_EN` undefined: no hold counter is built, `LONGPRESS_MS` is ignored, and clear comes only from `btn_clr_raw`.

## Structure
- `stopwatch_pkg` contains:
  - `btn_state_t` enum: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - `ms_to_cycles(clk_hz, ms)` function.
  - `STOPWATCH_CLK_HZ` constant.
- Sub-module `btn_debounce` (synchronizer + FSM + rise strobe), instantiated twice. The run/clear logic and the long-press counter live in the top module.

## Test plan
Use CLK_HZ=1000, DEBOUNCE_MS=4, LONGPRESS_MS=20 (DB_CYCLES=4, LP_CYCLES=20).
- Reset, then idle 10 cycles → `run`=0, `clr_pulse`=0, `ss_db`=0.
- `btn_ss_raw` high at edge 0, held → `ss_db`=1 at edge 6, `run`=1 at edge 7. Release, then press again → `run` returns to 0.
- `btn_ss_raw` bounced 1,0,1,0 for 3 cycles each, then released → no `run` change, `ss_db` stays 0.
- Both raw buttons rise at the same edge while `run`=1 → at edge 7, `clr_pulse`=1 for one cycle and `run`=0.
- Assert reset while `btn_ss_raw` is held mid-PRESS_WAIT → outputs 0 immediately. After reset release with the button still held, `run`=1 exactly 7 cycles after the first edge following reset release.
- BTN_LONGPRESS_EN: hold `btn_ss_raw` for 40 cycles → `run`=1 at edge 7, then `clr_pulse` once at edge 7+20, with `run`=0. Without the macro, the same stimulus gives `run`=1 and no `clr_pulse`.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch button-control slice.
package stopwatch_pkg;

   localparam int STOPWATCH_CLK_HZ = 100_000_000;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   function automatic int ms_to_cycles(input int clk_hz, input int ms);
      return clk_hz / 1000 * ms;
   endfunction

endpackage

// File: rtl/stopwatch_btn_debounce.sv
// One button: 2-flop synchronizer, debounce FSM and a press (rise) strobe.
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic db_level,
   output logic press_strobe
);

   logic [1:0]       sync_q;
   logic             sync;
   btn_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             db_prev;

   assign sync = sync_q[1];

   // NOTE: asynchronous reset in the sensitivity list; every register here
   // clears the moment reset rises, not at the next clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b00;
      end else begin
         // NOTE: non-blocking so both flops sample the old value on the same edge.
         sync_q <= {sync_q[0], btn_raw};
      end
   end

   // The counter only ever reaches DB_CYCLES-1 before a state change, so it cannot wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RELEASED;
         cnt   <= '0;
      end else begin
         case (state)
            RELEASED: if (sync) begin
               state <= PRESS_WAIT;
               cnt   <= '0;
            end
            PRESS_WAIT:
               if (!sync)                             state <= RELEASED;
               else if (cnt == CNT_W'(DB_CYCLES - 1)) state <= PRESSED;
               else                                   cnt   <= cnt + 1'b1;
            PRESSED: if (!sync) begin
               state <= RELEASE_WAIT;
               cnt   <= '0;
            end
            RELEASE_WAIT:
               if (sync)                              state <= PRESSED;
               else if (cnt == CNT_W'(DB_CYCLES - 1)) state <= RELEASED;
               else                                   cnt   <= cnt + 1'b1;
            default: state <= RELEASED;
         endcase
      end
   end

   assign db_level = (state == PRESSED) || (state == RELEASE_WAIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) db_prev <= 1'b0;
      else       db_prev <= db_level;
   end

   // Only the 0->1 edge is an event; release and holding produce nothing.
   assign press_strobe = db_level & ~db_prev;

endmodule

// File: rtl/stopwatch_btn_ctrl.sv
// Button conditioning and run/clear control for the stopwatch counter.
// Optional long-press clear on start/stop: define BTN_LONGPRESS_EN.
module stopwatch_btn_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ       = STOPWATCH_CLK_HZ,
   parameter int DEBOUNCE_MS  = 10,
   parameter int LONGPRESS_MS = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_ss_raw,
   input  logic btn_clr_raw,
   output logic run,
   output logic clr_pulse,
   output logic ss_db,
   output logic clr_db
);

   localparam int DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int LP_CYCLES = ms_to_cycles(CLK_HZ, LONGPRESS_MS);
   localparam int CNT_W     =
      $clog2(((DB_CYCLES > LP_CYCLES) ? DB_CYCLES : LP_CYCLES) + 1);

   logic ss_strobe;
   logic clr_strobe;
   logic lp_fire;
   logic clear_req;

   btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_ss (
      .clk          (clk),
      .reset        (reset),
      .btn_raw      (btn_ss_raw),
      .db_level     (ss_db),
      .press_strobe (ss_strobe)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_clr (
      .clk          (clk),
      .reset        (reset),
      .btn_raw      (btn_clr_raw),
      .db_level     (clr_db),
      .press_strobe (clr_strobe)
   );

`ifdef BTN_LONGPRESS_EN
   logic [CNT_W-1:0] hold_cnt;
   logic             lp_fired;

   // hold_cnt equals the number of edges the debounced level has been high, capped at LP_CYCLES.
   assign lp_fire = ss_db && (hold_cnt == CNT_W'(LP_CYCLES)) && !lp_fired;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt <= '0;
         lp_fired <= 1'b0;
      end else if (!ss_db) begin
         hold_cnt <= '0;
         lp_fired <= 1'b0;
      end else begin
         if (hold_cnt != CNT_W'(LP_CYCLES)) hold_cnt <= hold_cnt + 1'b1;
         if (lp_fire)                       lp_fired <= 1'b1;
      end
   end
`else
   assign lp_fire = 1'b0;
`endif

   assign clear_req = clr_strobe | lp_fire;

   // Clear has priority and swallows a same-cycle start/stop strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run       <= 1'b0;
         clr_pulse <= 1'b0;
      end else if (clear_req) begin
         run       <= 1'b0;
         clr_pulse <= 1'b1;
      end else begin
         clr_pulse <= 1'b0;
         if (ss_strobe) run <= ~run;
      end
   end

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Directed bench for stopwatch_btn_ctrl with DB_CYCLES=4, LP_CYCLES=20.
module tb_stopwatch_btn_ctrl;

   logic clk = 1'b0;
   logic reset;
   logic btn_ss_raw;
   logic btn_clr_raw;
   logic run;
   logic clr_pulse;
   logic ss_db;
   logic clr_db;

   int checks   = 0;
   int failures = 0;

`ifdef BTN_LONGPRESS_EN
   localparam bit LP_EN = 1'b1;
`else
   localparam bit LP_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   stopwatch_btn_ctrl #(
      .CLK_HZ       (1000),
      .DEBOUNCE_MS  (4),
      .LONGPRESS_MS (20)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_ss_raw  (btn_ss_raw),
      .btn_clr_raw (btn_clr_raw),
      .run         (run),
      .clr_pulse   (clr_pulse),
      .ss_db       (ss_db),
      .clr_db      (clr_db)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges; return at the following falling edge for sampling/driving.
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   int  pulses;
   logic saw_db;

   initial begin
      reset       = 1'b1;
      btn_ss_raw  = 1'b0;
      btn_clr_raw = 1'b0;
      step(2);
      reset = 1'b0;
      step(10);
      check("reset_run",    run,       0);
      check("reset_clr",    clr_pulse, 0);
      check("reset_ss_db",  ss_db,     0);
      check("reset_clr_db", clr_db,    0);

      // Clean press: raw sampled at edge 0
      btn_ss_raw = 1'b1;
      step(6);
      check("ss_db_edge5", ss_db, 0);
      step(1);
      check("ss_db_edge6", ss_db, 1);
      check("run_edge6",   run,   0);
      step(1);
      check("run_edge7",   run,   1);
      check("clr_edge7",   clr_pulse, 0);
      btn_ss_raw = 1'b0;
      step(12);
      check("run_after_release", run, 1);
      check("ss_db_released",    ss_db, 0);
      btn_ss_raw = 1'b1;
      step(8);
      check("run_second_press", run, 0);
      btn_ss_raw = 1'b0;
      step(12);

      // Bounce shorter than DB_CYCLES
      saw_db = 1'b0;
      for (int ph = 0; ph < 4; ph++) begin
         btn_ss_raw = (ph % 2 == 0);
         for (int c = 0; c < 3; c++) begin
            step(1);
            saw_db |= ss_db;
         end
      end
      btn_ss_raw = 1'b0;
      for (int c = 0; c < 12; c++) begin
         step(1);
         saw_db |= ss_db;
      end
      check("bounce_ss_db", saw_db, 0);
      check("bounce_run",   run,    0);

      // Simultaneous presses while running: clear wins
      btn_ss_raw = 1'b1;
      step(8);
      check("prep_run", run, 1);
      btn_ss_raw = 1'b0;
      step(12);
      btn_ss_raw  = 1'b1;
      btn_clr_raw = 1'b1;
      step(7);
      check("both_e6_clr", clr_pulse, 0);
      check("both_e6_run", run,       1);
      step(1);
      check("both_e7_clr", clr_pulse, 1);
      check("both_e7_run", run,       0);
      check("both_clr_db", clr_db,    1);
      step(1);
      check("both_e8_clr", clr_pulse, 0);
      check("both_e8_run", run,       0);
      btn_ss_raw  = 1'b0;
      btn_clr_raw = 1'b0;
      step(12);

      // Reset mid-PRESS_WAIT while running
      btn_ss_raw = 1'b1;
      step(8);
      check("prep_run2", run, 1);
      btn_ss_raw = 1'b0;
      step(12);
      btn_ss_raw = 1'b1;
      step(4);
      #2 reset = 1'b1;
      #1;
      check("rst_async_run",   run,       0);
      check("rst_async_ss_db", ss_db,     0);
      check("rst_async_clr",   clr_pulse, 0);
      @(negedge clk);
      reset = 1'b0;
      step(7);
      check("rst_held_e6_run", run, 0);
      step(1);
      check("rst_held_e7_run", run, 1);
      btn_ss_raw = 1'b0;
      step(12);

      // Clear while running, then hold: single pulse only
      btn_clr_raw = 1'b1;
      step(7);
      check("clr_e6", clr_pulse, 0);
      step(1);
      check("clr_e7",     clr_pulse, 1);
      check("clr_e7_run", run,       0);
      pulses = 0;
      repeat (30) begin
         step(1);
         pulses += int'(clr_pulse);
      end
      check("clr_hold_repeat", pulses, 0);
      btn_clr_raw = 1'b0;
      step(12);

      // Clear while stopped
      btn_clr_raw = 1'b1;
      step(8);
      check("clr_stopped_pulse", clr_pulse, 1);
      check("clr_stopped_run",   run,       0);
      btn_clr_raw = 1'b0;
      step(12);

      // Long hold of start/stop
      btn_ss_raw = 1'b1;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         step(1);
         if (k == 7)  check("hold_run_e7", run, 1);
         if (k == 27) check("hold_clr_e27", clr_pulse, LP_EN ? 1 : 0);
         pulses += int'(clr_pulse);
      end
      check("hold_pulses", pulses, LP_EN ? 1 : 0);
      check("hold_run_end", run, LP_EN ? 0 : 1);
      btn_ss_raw = 1'b0;
      step(12);
      check("hold_run_released", run, LP_EN ? 0 : 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
